fp_op_sequencer: RTL and testbench
==================================

Name: fp_op_sequencer

Overview:
- Issue/retire stage wrapped around the mul_div floating-point unit.
- Accepts operand requests over a valid/ready handshake and drives mul_div's a/b/sel/en pins.
- Waits the unit's fixed pipeline latency, then captures R and the five exception flags into a result register presented over a valid/ready handshake.
- Keeps IEEE-style sticky exception status for software readout.

Parameters:
- WIDTH, 32, operand/result width; IEEE-754 binary32 encoding.
- LATENCY, 2, edges from mul_div sampling en=1 to R/flags being valid; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge
- arst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_a  in  WIDTH  operand a
- req_b  in  WIDTH  operand b
- req_sel  in  1  0 = multiply, 1 = divide (a/b)
- md_en  out  1  to mul_div en
- md_a  out  WIDTH  to mul_div a
- md_b  out  WIDTH  to mul_div b
- md_sel  out  1  to mul_div sel
- md_R  in  WIDTH  from mul_div R
- md_flags  in  5  from mul_div {io_flag, dz_flag, of_flag, uf_flag, i_flag}
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_R  out  WIDTH  captured result
- rsp_flags  out  5  captured flags, same bit order as md_flags
- sticky_flags  out  5  OR-accumulated flags since reset or last clear
- sticky_clr  in  1  synchronous clear of sticky_flags

Behaviour:
- Reset (arst=1, asynchronous): state=IDLE, counter=0. All outputs are 0 except req_ready, which is 1.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
- req_ready = (state==IDLE), registered. It is never high in any other state, so at most one operation is in flight.
- IDLE: on req_valid && req_ready at edge E0, register req_a/req_b/req_sel into md_a/md_b/md_sel, then go to ISSUE.
- ISSUE: md_en=1 for exactly this one cycle. At edge E1, go to WAIT with cnt=1.
- md_a/md_b/md_sel hold stable from E0 until the next accepted request; they are not cleared on retire.
- WAIT: at each edge, if cnt==LATENCY, capture md_R into rsp_R and md_flags into rsp_flags, set rsp_valid=1 and go to HOLD; otherwise cnt++.
  - The capture therefore occurs at edge E1+LATENCY.
  - rsp_valid rises LATENCY+1 edges after the request handshake.
  - Counter width is 4 bits.
- HOLD: rsp_valid, rsp_R and rsp_flags stay stable until rsp_ready=1 at an edge. On that edge, rsp_valid=0, state goes to IDLE and req_ready=1 on the following cycle.
- rsp_ready while in IDLE/ISSUE/WAIT has no effect.
- Sticky flags:
  - At the capture edge, sticky_flags |= md_flags.
  - sticky_clr=1 at a non-capture edge sets sticky_flags to 0.
  - sticky_clr=1 at the capture edge sets sticky_flags to md_flags (clear first, then set); the new operation's exceptions are never lost.
- Reset mid-operation returns to IDLE immediately. md_en drops asynchronously and the in-flight result is discarded; any later R from mul_div is ignored because the FSM is not in WAIT.
- No arithmetic is performed here; data passes through bit-exact.

Test Plan:
- Mul, LATENCY=2: req_a=0x40000000, req_b=0x40400000, sel=0, rsp_ready=1 → md_en high for exactly one cycle; rsp_valid rises 3 edges after the handshake; rsp_R=0x40C00000, rsp_flags=0.
- Div by zero: a=0x3F800000, b=0x00000000, sel=1 → rsp_R=0x7F800000, rsp_flags=5'b01000, sticky_flags=5'b01000.
- Backpressure: 1.5*2.0 (0x3FC00000*0x40000000) with rsp_ready=0 for 10 cycles → rsp_valid and rsp_R=0x40400000 held stable; req_ready=0 throughout; on rsp_ready=1, one handshake occurs and req_ready=1 the next cycle.
- Sticky accumulate/clear: 0/0 (io) then 1/0 (dz) → sticky=5'b11000; sticky_clr pulsed exactly at the second capture edge → sticky=5'b01000.
- Reset mid-WAIT: assert arst one cycle after md_en → all outputs 0 and req_ready=1 immediately; no rsp_valid appears; the next request completes normally.
- Back-to-back: 20 random requests with req_valid held high and rsp_ready=1 → each completes in LATENCY+3 cycles request-to-next-accept; results match the mul_div reference model in order.

Source files
------------

// File: rtl/fp_op_sequencer.sv
// Issue/retire wrapper around the mul_div FP unit: one operation in flight,
// fixed-latency result capture, and sticky IEEE exception status.
module fp_op_sequencer #(
   parameter int WIDTH   = 32,
   parameter int LATENCY = 2
) (
   input  logic             clk,
   input  logic             arst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   input  logic             req_sel,
   output logic             md_en,
   output logic [WIDTH-1:0] md_a,
   output logic [WIDTH-1:0] md_b,
   output logic             md_sel,
   input  logic [WIDTH-1:0] md_R,
   input  logic [4:0]       md_flags,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_R,
   output logic [4:0]       rsp_flags,
   output logic [4:0]       sticky_flags,
   input  logic             sticky_clr
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

   localparam logic [3:0] LAT4 = 4'(LATENCY);

   state_t           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d;
   logic             sel_q, sel_d, vld_q, vld_d;
   logic [4:0]       fl_q, fl_d, st_q, st_d;
   logic             capture;

   assign capture = (state_q == WAIT) && (cnt_q == LAT4);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      sel_d   = sel_q;
      r_d     = r_q;
      fl_d    = fl_q;
      vld_d   = vld_q;
      case (state_q)
         IDLE: if (req_valid) begin
            a_d     = req_a;
            b_d     = req_b;
            sel_d   = req_sel;
            state_d = ISSUE;
         end
         ISSUE: begin
            cnt_d   = 4'd1;
            state_d = WAIT;
         end
         WAIT: begin
            if (capture) begin
               r_d     = md_R;
               fl_d    = md_flags;
               vld_d   = 1'b1;
               state_d = HOLD;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         HOLD: if (rsp_ready) begin
            vld_d   = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Clear applies before the capture OR so a same-edge clear keeps the new flags.
   always_comb begin
      st_d = st_q;
      if (sticky_clr) st_d = '0;
      if (capture)    st_d = st_d | md_flags;
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sel_q   <= 1'b0;
         r_q     <= '0;
         fl_q    <= '0;
         vld_q   <= 1'b0;
         st_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sel_q   <= sel_d;
         r_q     <= r_d;
         fl_q    <= fl_d;
         vld_q   <= vld_d;
         st_q    <= st_d;
      end
   end

   assign req_ready    = (state_q == IDLE);
   assign md_en        = (state_q == ISSUE);
   assign md_a         = a_q;
   assign md_b         = b_q;
   assign md_sel       = sel_q;
   assign rsp_valid    = vld_q;
   assign rsp_R        = r_q;
   assign rsp_flags    = fl_q;
   assign sticky_flags = st_q;

endmodule

// File: tb/tb_fp_op_sequencer.sv
// Bench for fp_op_sequencer with a fixed-latency stand-in for mul_div.
module tb_fp_op_sequencer;
   localparam int W   = 32;
   localparam int LAT = 2;

   logic          clk = 1'b0, arst = 1'b1;
   logic          req_valid = 1'b0, req_ready, req_sel = 1'b0;
   logic [W-1:0]  req_a = '0, req_b = '0;
   logic          md_en, md_sel;
   logic [W-1:0]  md_a, md_b, md_R;
   logic [4:0]    md_flags;
   logic          rsp_valid, rsp_ready = 1'b0;
   logic [W-1:0]  rsp_R;
   logic [4:0]    rsp_flags, sticky_flags;
   logic          sticky_clr = 1'b0;

   int errors = 0, checks = 0;

   fp_op_sequencer #(.WIDTH(W), .LATENCY(LAT)) dut (
      .clk(clk), .arst(arst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
      .md_en(md_en), .md_a(md_a), .md_b(md_b), .md_sel(md_sel),
      .md_R(md_R), .md_flags(md_flags),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_R(rsp_R), .rsp_flags(rsp_flags),
      .sticky_flags(sticky_flags), .sticky_clr(sticky_clr)
   );

   always #5 clk = ~clk;

   // Reference mul_div behaviour: exact answers for the directed cases,
   // IEEE divide-by-zero / invalid handling, and a deterministic mix otherwise.
   function automatic logic [36:0] md_fn(input logic [31:0] a, input logic [31:0] b, input logic sel);
      logic [31:0] r;
      if (!sel && a == 32'h40000000 && b == 32'h40400000) return {5'b0, 32'h40C00000};
      if (!sel && a == 32'h3FC00000 && b == 32'h40000000) return {5'b0, 32'h40400000};
      if (sel && b[30:0] == 31'd0) begin
         if (a[30:0] == 31'd0) return {5'b10000, 32'h7FC00000};
         return {5'b01000, a[31] ^ b[31], 31'h7F800000};
      end
      r = a ^ {b[15:0], b[31:16]} ^ {sel, 31'h1234567};
      return {(a[4:0] ^ b[9:5]) & 5'b00111, r};
   endfunction

   // Stand-in unit: result of the operand set sampled with en appears LAT edges later;
   // junk otherwise so a mistimed capture is visible.
   logic [36:0] pl [1:LAT];
   always @(posedge clk) begin
      pl[1] <= md_en ? md_fn(md_a, md_b, md_sel) : {5'b10101, 32'hDEADBEEF};
      for (int k = 2; k <= LAT; k++) pl[k] <= pl[k-1];
   end
   assign md_R     = pl[LAT][31:0];
   assign md_flags = pl[LAT][36:32];

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // Drives one request; returns edges from handshake to rsp_valid and md_en high cycles.
   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sel,
                       output int lat, output int en_cyc);
      int g;
      lat = -1; en_cyc = 0; g = 0;
      while (!req_ready && g < 50) begin tick(); g++; end
      req_a = a; req_b = b; req_sel = sel; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      for (int k = 1; k <= 30; k++) begin
         if (md_en) en_cyc++;
         tick();
         if (rsp_valid) begin lat = k; break; end
      end
   endtask

   task automatic test_reset();
      arst = 1'b1; #1;
      checks++;
      if ({req_ready, md_en, rsp_valid, md_a, md_b, md_sel, rsp_R, rsp_flags, sticky_flags} !==
          {1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 5'd0, 5'd0}) begin
         errors++;
         $display("FAIL reset: req_ready=%b md_en=%b rsp_valid=%b md_a=%h rsp_R=%h sticky=%b (want 1,0,0,0,0,0)",
                  req_ready, md_en, rsp_valid, md_a, rsp_R, sticky_flags);
      end
      @(negedge clk); arst = 1'b0;
      tick();
   endtask

   task automatic test_mul();
      int lat, en;
      rsp_ready = 1'b1;
      send(32'h40000000, 32'h40400000, 1'b0, lat, en);
      checks++;
      if (lat !== LAT + 1) begin errors++; $display("FAIL mul_latency: got %0d want %0d", lat, LAT + 1); end
      checks++;
      if (en !== 1) begin errors++; $display("FAIL mul_en_cycles: got %0d want 1", en); end
      checks++;
      if (rsp_R !== 32'h40C00000 || rsp_flags !== 5'd0) begin
         errors++; $display("FAIL mul_result: got %h/%b want 40c00000/00000", rsp_R, rsp_flags);
      end
      checks++;
      if (md_a !== 32'h40000000 || md_b !== 32'h40400000 || md_sel !== 1'b0) begin
         errors++; $display("FAIL mul_operands_held: got %h %h %b", md_a, md_b, md_sel);
      end
      tick();
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
         errors++; $display("FAIL mul_retire: rsp_valid=%b req_ready=%b want 0,1", rsp_valid, req_ready);
      end
   endtask

   task automatic test_div_zero();
      int lat, en;
      sticky_clr = 1'b1; tick(); sticky_clr = 1'b0;
      rsp_ready = 1'b1;
      send(32'h3F800000, 32'h00000000, 1'b1, lat, en);
      checks++;
      if (rsp_R !== 32'h7F800000 || rsp_flags !== 5'b01000 || sticky_flags !== 5'b01000) begin
         errors++;
         $display("FAIL div_zero: got R=%h fl=%b st=%b want 7f800000/01000/01000", rsp_R, rsp_flags, sticky_flags);
      end
      tick();
   endtask

   task automatic test_backpressure();
      int lat, en;
      logic ok;
      rsp_ready = 1'b0;
      send(32'h3FC00000, 32'h40000000, 1'b0, lat, en);
      ok = 1'b1;
      for (int k = 0; k < 10; k++) begin
         if (rsp_valid !== 1'b1 || rsp_R !== 32'h40400000 || req_ready !== 1'b0) ok = 1'b0;
         tick();
      end
      checks++;
      if (ok !== 1'b1 || rsp_valid !== 1'b1 || rsp_R !== 32'h40400000) begin
         errors++; $display("FAIL backpressure_hold: valid=%b R=%h req_ready=%b want 1/40400000/0",
                            rsp_valid, rsp_R, req_ready);
      end
      rsp_ready = 1'b1;
      tick();
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
         errors++; $display("FAIL backpressure_release: valid=%b req_ready=%b want 0,1", rsp_valid, req_ready);
      end
   endtask

   task automatic test_sticky();
      int lat, en;
      rsp_ready = 1'b1;
      sticky_clr = 1'b1; tick(); sticky_clr = 1'b0;
      checks++;
      if (sticky_flags !== 5'd0) begin errors++; $display("FAIL sticky_clear_idle: got %b want 00000", sticky_flags); end
      send(32'h00000000, 32'h00000000, 1'b1, lat, en); tick();
      send(32'h3F800000, 32'h00000000, 1'b1, lat, en); tick();
      checks++;
      if (sticky_flags !== 5'b11000) begin errors++; $display("FAIL sticky_accum: got %b want 11000", sticky_flags); end
      // Second pass: clear lands exactly on the dz capture edge.
      send(32'h00000000, 32'h00000000, 1'b1, lat, en); tick();
      req_a = 32'h3F800000; req_b = 32'h0; req_sel = 1'b1; req_valid = 1'b1;
      tick(); req_valid = 1'b0;
      for (int k = 1; k < LAT + 1; k++) tick();
      sticky_clr = 1'b1;
      tick();
      sticky_clr = 1'b0;
      checks++;
      if (rsp_valid !== 1'b1 || sticky_flags !== 5'b01000) begin
         errors++; $display("FAIL sticky_clr_at_capture: valid=%b sticky=%b want 1/01000", rsp_valid, sticky_flags);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      int lat, en;
      logic seen;
      rsp_ready = 1'b1;
      req_a = 32'h40000000; req_b = 32'h40400000; req_sel = 1'b0; req_valid = 1'b1;
      tick(); req_valid = 1'b0;
      tick();
      arst = 1'b1; #1;
      checks++;
      if ({md_en, rsp_valid, req_ready, md_a, md_b, rsp_R, rsp_flags, sticky_flags} !==
          {1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0}) begin
         errors++; $display("FAIL reset_mid: md_en=%b valid=%b req_ready=%b md_a=%h sticky=%b want 0,0,1,0,0",
                            md_en, rsp_valid, req_ready, md_a, sticky_flags);
      end
      tick();
      @(negedge clk); arst = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 6; k++) begin tick(); if (rsp_valid) seen = 1'b1; end
      checks++;
      if (seen !== 1'b0) begin errors++; $display("FAIL reset_mid_no_rsp: saw rsp_valid=1 want 0"); end
      send(32'h3FC00000, 32'h40000000, 1'b0, lat, en);
      checks++;
      if (lat !== LAT + 1 || rsp_R !== 32'h40400000) begin
         errors++; $display("FAIL reset_mid_recover: lat=%0d R=%h want %0d/40400000", lat, rsp_R, LAT + 1);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [36:0] expq [$];
      logic [36:0] e;
      logic [4:0]  st_exp;
      int n_acc, n_rsp, last_acc, cyc;
      logic acc;
      sticky_clr = 1'b1; tick(); sticky_clr = 1'b0;
      st_exp = '0; n_acc = 0; n_rsp = 0; last_acc = -1; cyc = 0;
      rsp_ready = 1'b1;
      req_a = $urandom; req_b = $urandom; req_sel = 1'($urandom_range(0, 1));
      req_valid = 1'b1;
      while (n_rsp < 20 && cyc < 400) begin
         acc = req_ready && req_valid;
         if (acc) expq.push_back(md_fn(req_a, req_b, req_sel));
         tick(); cyc++;
         if (acc) begin
            if (last_acc >= 0) begin
               checks++;
               if (cyc - last_acc !== LAT + 3) begin
                  errors++; $display("FAIL b2b_interval: req %0d got %0d want %0d", n_acc, cyc - last_acc, LAT + 3);
               end
            end
            last_acc = cyc; n_acc++;
            if (n_acc < 20) begin
               req_a = $urandom; req_b = $urandom; req_sel = 1'($urandom_range(0, 1));
               if ($urandom_range(0, 3) == 0) req_b = 32'h0;
            end else req_valid = 1'b0;
         end
         if (rsp_valid && expq.size() > 0) begin
            e = expq.pop_front();
            st_exp |= e[36:32];
            checks++;
            if (rsp_R !== e[31:0] || rsp_flags !== e[36:32]) begin
               errors++; $display("FAIL b2b_result: rsp %0d got %h/%b want %h/%b",
                                  n_rsp, rsp_R, rsp_flags, e[31:0], e[36:32]);
            end
            n_rsp++;
         end
      end
      req_valid = 1'b0;
      checks++;
      if (n_rsp !== 20) begin errors++; $display("FAIL b2b_count: got %0d responses want 20", n_rsp); end
      checks++;
      if (sticky_flags !== st_exp) begin errors++; $display("FAIL b2b_sticky: got %b want %b", sticky_flags, st_exp); end
      tick();
   endtask

   initial begin
      test_reset();
      test_mul();
      test_div_zero();
      test_backpressure();
      test_sticky();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
